ps2_rx_queue: RTL and testbench
===============================

# ps2_rx_queue

Parametrised PS/2 keyboard receiver that replaces the single-register scan-code capture with a validated, buffered key-event stream. It synchronises the PS/2 lines, deframes 11-bit frames with stop-bit checking, inactivity timeout and optional parity checking, and folds the E0/F0 prefix bytes into one key event per make/break code. Events are queued in a first-word-fall-through FIFO with a valid/ready output. The block sits between the PS/2 pins and any consumer logic, such as the display or command decoder.

## Interface
- SYNC_STAGES, 3: flip-flop stages on each PS/2 input; minimum 2.
- FIFO_DEPTH, 8: event queue depth; power of two, minimum 2.
- TIMEOUT_CYCLES, 100000: clk cycles without a PS/2 falling edge before a partial frame is abandoned.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- out_data  out  10  head event: [9] extended (E0 seen), [8] release (F0 seen), [7:0] scan code.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head event.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued events.
- overflow  out  1  one-cycle pulse: an event was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: a frame was discarded (bad start continuation, bad stop, bad parity or timeout).

## Operation
- Synchronisers reset to all-ones. A falling edge is detected when the last two ps2_clk stages read 1 then 0. The data bit is the last ps2_data stage.
- Receiver FSM (acts only in falling-edge cycles, except for the timeout):
  - IDLE: a falling edge with data=0 goes to DATA with bit index 0. A falling edge with data=1 is ignored (glitch) and the FSM stays in IDLE.
  - DATA: bits are shifted in LSB first. After the 8th bit the FSM goes to PARITY.
  - PARITY: the parity bit is captured, then the FSM goes to STOP.
  - STOP: if data=1 (and parity passes when enabled), a byte_done strobe is registered and the FSM goes to IDLE. Otherwise frame_err pulses and the FSM goes to IDLE.
- Timeout counter: cleared on every falling edge and held at 0 in IDLE. When it reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM goes to IDLE, frame_err pulses and the partial byte is dropped.
- Assembler, acting on byte_done:
  - 0xE0 sets the ext flag.
  - 0xF0 sets the rel flag.
  - Any other byte pushes {ext, rel, byte} and clears both flags.
  - frame_err also clears both flags.
- FIFO:
  - Push when an event is pending and the FIFO is not full. When full, the event is dropped and overflow pulses.
  - Pop when out_valid and out_ready are both 1.
  - Simultaneous push and pop while full: both happen and fifo_count is unchanged.
  - Simultaneous push and pop while empty: only the push happens.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is an exact count, 0..FIFO_DEPTH.

## Timing
- Reset values: out_data=0, out_valid=0, fifo_count=0, overflow=0, frame_err=0. The FSM is in IDLE, ext and rel are clear, and the timeout counter is 0.
- Reset asserted mid-frame discards the partial frame, the prefix flags and all queued events. No pulse is emitted on reset exit.
- Pin to detection: a falling edge on ps2_clk is detected SYNC_STAGES+1 clk cycles after it settles at the pin.
- Let cycle D be the clock edge on which the stop-bit falling edge is detected:
  - byte_done is registered at D.
  - The FIFO is written at D+1, and out_valid/fifo_count are updated after D+1.
  - frame_err for a bad stop or bad parity is high during the cycle after D.
- out_data is valid combinationally from the head entry whenever out_valid=1. After a pop, the next entry is presented on the following cycle.
- overflow is high for the one cycle after the dropped write attempt (D+1).

## Configuration
- PS2_PARITY_CHECK_EN defined: the STOP state also requires odd parity over the 8 data bits plus the parity bit. A failure pulses frame_err and the byte is discarded without touching ext/rel until the flag clear.
- PS2_PARITY_CHECK_EN undefined: the parity bit is captured and ignored. Only the stop bit and the timeout can cause frame_err.

## Test plan
- Frame 0x1C (odd parity 0, stop 1), out_ready=1 -> one event with out_data=0x01C; out_valid is high for exactly 1 cycle; frame_err stays 0.
- Frames E0, F0, 0x74 -> a single event out_data=0x374. A following frame 0x74 -> out_data=0x074.
- out_ready=0 and FIFO_DEPTH+1 frames 0x01..0x09 -> fifo_count=8 and one overflow pulse on the 9th frame. Draining returns 0x01..0x08 in order.
- Stop bit driven 0 on frame 0x1C -> frame_err pulse and no event. With the macro defined, wrong parity -> frame_err pulse and no event.
- After 5 clock pulses, ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse. A following valid frame 0x2A -> out_data=0x02A.
- rst asserted during bit 4 with 3 events queued -> all outputs 0 immediately. The next complete frame 0x1C -> out_data=0x01C.

Source files
------------

// File: rtl/ps2_rx_queue.sv
// rtl/ps2_rx_queue.sv - PS/2 receiver folding E0/F0 prefixes into key events queued in an FWFT FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_queue #(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic [9:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          frame_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   fall, bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    rx_state_t     state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shift_q  <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !bit_in) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: if (fall) begin
                shift_d = {bit_in, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                parity_d = bit_in;
`endif
                state_d = STOP;
            end
            STOP: if (fall) begin
                if (bit_in && parity_ok) done_d = 1'b1;
                else                     ferr_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Inactivity watchdog only runs while a frame is in progress.
        if (state_q != IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    logic ext_q, rel_q;
    logic push_req;

    assign push_req = done_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (ferr_q) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (done_q) begin
            if (shift_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, pop, wr_en;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = out_valid && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {ext_q, rel_q, shift_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            ovf_q   <= push_req && full && !pop;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_queue.sv
// tb/tb_ps2_rx_queue.sv - randomized scoreboard bench for ps2_rx_queue.
module tb_ps2_rx_queue;
    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          out_ready = 1'b0;
    logic [9:0]    out_data;
    logic          out_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          frame_err;

    always #5 clk = ~clk;

    ps2_rx_queue #(
        .SYNC_STAGES(3),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    int         n_vec = 0, n_bad = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_ev;
    int         exp_ferr = 0, exp_ovf = 0, obs_ferr = 0, obs_ovf = 0, valid_cycles = 0;
    bit         m_ext = 1'b0, m_rel = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) obs_ferr++;
            if (overflow)  obs_ovf++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %h expected none", out_data);
                end else begin
                    exp_ev = sb.pop_front();
                    if (out_data !== exp_ev) begin
                        n_bad++;
                        $display("FAIL event_data: got %h expected %h", out_data, exp_ev);
                    end
                end
            end
        end
    end

    // Reference model: one complete frame, applied at the key-event level.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        bit good;
        good = stop_ok;
`ifdef PS2_PARITY_CHECK_EN
        good = good && par_ok;
`endif
        if (!good) begin
            exp_ferr++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            // With the consumer stalled for the whole frame, occupancy equals the pending list.
            if (!out_ready && sb.size() >= DEPTH) exp_ovf++;
            else sb.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok = 1'b1,
                              input bit par_ok = 1'b1, input int nbits = 11);
        logic        par;
        logic [10:0] bits;
        par  = ~^b;
        if (!par_ok) par = ~par;
        bits = {stop_ok, par, b, 1'b0};
        if (nbits == 11) model_frame(b, stop_ok, par_ok);
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] rb;
        int         r;

        repeat (4) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        out_ready = 1'b1;
        valid_cycles = 0;
        send_frame(8'h1C);
        check("single_valid_cycles", valid_cycles, 1);
        check("single_frame_err", obs_ferr, exp_ferr);

        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h74);
        send_frame(8'h74);
        wait_drain();

        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i));
        check("full_fifo_count", fifo_count, DEPTH);
        check("full_overflow", obs_ovf, exp_ovf);
        out_ready = 1'b1;
        wait_drain();
        check("drained_fifo_count", fifo_count, 0);

        send_frame(8'h1C, 1'b0, 1'b1);
        check("bad_stop_frame_err", obs_ferr, exp_ferr);
        send_frame(8'h1C, 1'b1, 1'b0);
        check("bad_parity_frame_err", obs_ferr, exp_ferr);
        wait_drain();

        send_frame(8'hE0);
        send_frame(8'h55, 1'b1, 1'b1, 5);
        repeat (TMO + 40) @(posedge clk);
        #1;
        exp_ferr++;
        m_ext = 1'b0;
        m_rel = 1'b0;
        check("timeout_frame_err", obs_ferr, exp_ferr);
        send_frame(8'h2A);
        wait_drain();

        out_ready = 1'b0;
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        check("pre_reset_count", fifo_count, 3);
        send_frame(8'h44, 1'b1, 1'b1, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_out_data", out_data, 0);
        sb.delete();
        m_ext = 1'b0;
        m_rel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_frame(8'h1C);
        wait_drain();
        check("post_reset_frame_err", obs_ferr, exp_ferr);
        check("post_reset_overflow", obs_ovf, exp_ovf);

        for (int n = 0; n < 40; n++) begin
            out_ready = ($urandom % 3) != 0;
            r = $urandom % 8;
            if (r == 0)      rb = 8'hE0;
            else if (r == 1) rb = 8'hF0;
            else             rb = 8'($urandom);
            send_frame(rb, ($urandom % 10) != 0, ($urandom % 8) != 0);
        end
        out_ready = 1'b1;
        wait_drain();
        check("rand_frame_err", obs_ferr, exp_ferr);
        check("rand_overflow", obs_ovf, exp_ovf);
        check("rand_fifo_count", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
